// File: rtl/smul_acc_round.sv
`default_nettype none
// ============================================================================
// Module   : smul_acc_round
// Brief    : Accumulates groups of NTERMS signed products, then rounds
//            half-up, arithmetic-shifts right by SHIFT and saturates to
//            WIDTH_O bits. One result per group on a valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module smul_acc_round #(
  parameter int WIDTH_P = 31,
  parameter int NTERMS  = 8,
  parameter int SHIFT   = 7,
  parameter int WIDTH_O = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_P-1:0] in_prod,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_O-1:0] out_data,
  output logic               out_sat
);

  // One guard bit above the worst-case group sum keeps the rounding add exact.
  localparam int WIDTH_ACC = WIDTH_P + $clog2(NTERMS) + 1;
  localparam int CNT_W     = $clog2(NTERMS);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(NTERMS - 1);
  localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

  // Saturation bounds expressed at accumulator width for a signed compare.
  localparam logic signed [WIDTH_ACC-1:0] c_sat_max =
    {{(WIDTH_ACC - WIDTH_O + 1){1'b0}}, {(WIDTH_O - 1){1'b1}}};
  localparam logic signed [WIDTH_ACC-1:0] c_sat_min =
    {{(WIDTH_ACC - WIDTH_O + 1){1'b1}}, {(WIDTH_O - 1){1'b0}}};

  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic signed [WIDTH_ACC-1:0] acc_q, acc_d;
  logic                        out_valid_q, out_valid_d;
  logic [WIDTH_O-1:0]          out_data_q, out_data_d;
  logic                        out_sat_q, out_sat_d;

  logic                        w_last;
  logic                        w_in_fire;
  logic                        w_out_fire;
  logic signed [WIDTH_ACC-1:0] w_prod_ext;
  logic signed [WIDTH_ACC-1:0] w_sum;
  logic signed [WIDTH_ACC-1:0] w_r;

  assign w_last     = (cnt_q == c_last);
  // Only the final term must wait for the output slot to free up.
  assign in_ready   = !(w_last && out_valid_q && !out_ready);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid_q && out_ready;

  assign w_prod_ext = {{(WIDTH_ACC - WIDTH_P){in_prod[WIDTH_P-1]}}, in_prod};
  assign w_sum      = acc_q + w_prod_ext;

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [WIDTH_ACC-1:0] c_half = WIDTH_ACC'(1) << (SHIFT - 1);
      logic signed [WIDTH_ACC-1:0] w_rnd;
      assign w_rnd = w_sum + c_half;
      assign w_r   = w_rnd >>> SHIFT;
    end else begin : g_noround
      assign w_r = w_sum;
    end
  endgenerate

  // Next-state: term counting, accumulation, result capture and handshake.
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    if (w_out_fire) begin
      out_valid_d = 1'b0;
    end

    if (w_in_fire) begin
      if (w_last) begin
        cnt_d       = '0;
        out_valid_d = 1'b1;
        if (w_r > c_sat_max) begin
          out_data_d = {1'b0, {(WIDTH_O - 1){1'b1}}};
          out_sat_d  = 1'b1;
        end else if (w_r < c_sat_min) begin
          out_data_d = {1'b1, {(WIDTH_O - 1){1'b0}}};
          out_sat_d  = 1'b1;
        end else begin
          out_data_d = w_r[WIDTH_O-1:0];
          out_sat_d  = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + c_one;
        acc_d = (cnt_q == '0) ? w_prod_ext : w_sum;
      end
    end
  end

  // State registers with asynchronous clear; a reset mid-group drops the partial sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_smul_acc_round.sv
`default_nettype none
// ============================================================================
// Module   : tb_smul_acc_round
// Brief    : Self-checking bench for smul_acc_round (NTERMS=4, SHIFT=7).
// Revision : 1.0 - initial release
// ============================================================================
module tb_smul_acc_round;

  localparam int WP = 31;
  localparam int NT = 4;
  localparam int SH = 7;
  localparam int WO = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [WP-1:0] in_prod;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [WO-1:0] out_data;
  logic                 out_sat;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  smul_acc_round #(
    .WIDTH_P (WP),
    .NTERMS  (NT),
    .SHIFT   (SH),
    .WIDTH_O (WO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: exact integer sum, floor((sum + 2^(SH-1)) / 2^SH), then clamp.
  function automatic longint ref_unsat(input longint g[NT]);
    longint s = 0;
    longint t;
    longint q;
    foreach (g[i]) s += g[i];
    t = s + (longint'(1) << (SH - 1));
    q = t / (longint'(1) << SH);
    if (t < 0 && q * (longint'(1) << SH) != t) q--;
    return q;
  endfunction

  function automatic longint ref_data(input longint g[NT]);
    longint r = ref_unsat(g);
    longint mx = (longint'(1) << (WO - 1)) - 1;
    longint mn = -(longint'(1) << (WO - 1));
    if (r > mx) return mx;
    if (r < mn) return mn;
    return r;
  endfunction

  function automatic longint ref_sat(input longint g[NT]);
    longint r = ref_unsat(g);
    return ((r > (longint'(1) << (WO - 1)) - 1) || (r < -(longint'(1) << (WO - 1)))) ? 1 : 0;
  endfunction

  function automatic longint rnd_prod(input int bits);
    logic signed [WP-1:0] v;
    v = WP'($urandom());
    return longint'(v) >>> (WP - bits);
  endfunction

  // Present one term and return just after the edge that accepts it.
  task automatic push(input longint p, output bit stalled);
    int  n;
    bit  ok;
    in_valid = 1'b1;
    in_prod  = WP'(p);
    stalled  = 1'b0;
    n        = 0;
    forever begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      stalled = 1'b1;
      n++;
      if (n > 40) begin
        chk("push_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic run_group(input string tag, input longint g[NT]);
    bit st;
    foreach (g[i]) push(g[i], st);
    in_valid = 1'b0;
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, out_data, ref_data(g));
    chk({tag, "_sat"}, out_sat, ref_sat(g));
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    longint g[NT];
    longint ga[NT];
    longint gb[NT];
    bit     st;
    bit     stall_seen;
    int     start;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_prod   = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    rst = 1'b0;
    idle_cycle();

    // Basic group and rounding boundaries
    g = '{64, 64, 64, 64};
    run_group("basic", g);
    chk("basic_const", out_data, 2);
    idle_cycle();
    chk("basic_drain", out_valid, 0);
    g = '{64, 0, 0, 0};    run_group("rnd_p64", g);  chk("rnd_p64_const", out_data, 1);
    g = '{-64, 0, 0, 0};   run_group("rnd_m64", g);  chk("rnd_m64_const", out_data, 0);
    g = '{-65, 0, 0, 0};   run_group("rnd_m65", g);  chk("rnd_m65_const", out_data, -1);

    // Saturation both ways, then clear
    g = '{1 << 29, 1 << 29, 1 << 29, 1 << 29};
    run_group("sat_pos", g);
    chk("sat_pos_const", out_data, 32767);
    chk("sat_pos_flag", out_sat, 1);
    g = '{-(1 << 29), -(1 << 29), -(1 << 29), -(1 << 29)};
    run_group("sat_neg", g);
    chk("sat_neg_const", out_data, -32768);
    chk("sat_neg_flag", out_sat, 1);
    g = '{0, 0, 0, 0};
    run_group("sat_clr", g);
    chk("sat_clr_flag", out_sat, 0);
    idle_cycle();

    // Backpressure: hold result A while group B streams in
    out_ready = 1'b0;
    ga = '{1000, 2000, 3000, 4000};
    gb = '{-5000, 300, 7, -1};
    run_group("bp_a", ga);
    for (int i = 0; i < NT - 1; i++) begin
      push(gb[i], st);
      chk("bp_b_nonfinal_nostall", st, 0);
    end
    in_valid = 1'b1;
    in_prod  = WP'(gb[NT-1]);
    @(negedge clk);
    chk("bp_in_ready_low", in_ready, 0);
    idle_cycle();
    @(negedge clk);
    chk("bp_in_ready_low2", in_ready, 0);
    chk("bp_a_held_valid", out_valid, 1);
    chk("bp_a_held_data", out_data, ref_data(ga));
    idle_cycle();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_high", in_ready, 1);
    idle_cycle();
    in_valid = 1'b0;
    chk("bp_b_valid", out_valid, 1);
    chk("bp_b_data", out_data, ref_data(gb));
    idle_cycle();
    chk("bp_b_drain", out_valid, 0);

    // Asynchronous reset mid-group while a result is pending
    out_ready = 1'b0;
    g = '{rnd_prod(20), rnd_prod(20), rnd_prod(20), rnd_prod(20)};
    run_group("pre_rst", g);
    push(100, st);
    push(200, st);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_data", out_data, 0);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    g = '{128, 0, 0, 0};
    run_group("post_rst", g);
    chk("post_rst_const", out_data, 1);
    idle_cycle();

    // Streaming: three back-to-back groups, no stalls, one result every NT cycles
    stall_seen = 1'b0;
    start = cyc;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NT; i++) begin
        g[i] = rnd_prod(22);
        push(g[i], st);
        if (st) stall_seen = 1'b1;
      end
      chk("stream_valid", out_valid, 1);
      chk("stream_data", out_data, ref_data(g));
      chk("stream_sat", out_sat, ref_sat(g));
    end
    in_valid = 1'b0;
    chk("stream_no_stall", stall_seen, 0);
    chk("stream_cycles", cyc - start, 3 * NT);
    idle_cycle();

    // Random full-range groups (exercise saturation and rounding at random)
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NT; i++) g[i] = rnd_prod((k % 2 == 0) ? WP : 24);
      run_group("rand", g);
      idle_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
